fifo_axis_rd_port: RTL
======================

// Module: fifo_axis_rd_port
// PURPOSE
// - Read-side AXI-Stream master port of the FIFO. Sits directly downstream of the read pointer block and the RAM read port.
// - Issues read enables to the pointer block whenever the FIFO is non-empty and local buffer credit exists.
// - Captures RAM read data after a fixed latency and presents it on m_axis_* with full backpressure support.
// - Sustains one beat per cycle when m_axis_tready is held high.
// PARAMETERS
// - DLEN    32  data width in bits (RAM word = tdata)
// - RD_LAT  1   RAM read latency in cycles from ram_ren to valid i_ram_rdata; legal values 1 or 2
// - DEPTH   RD_LAT+1 (localparam)  output buffer entries; not overridable
// PORTS
// - clk            in   1     clock
// - rstn           in   1     asynchronous active-low reset
// - i_rempty       in   1     FIFO empty flag from read pointer block
// - o_ren          out  1     read request to read pointer block; never asserted while i_rempty=1
// - i_ram_rdata    in   DLEN  RAM read data, valid RD_LAT cycles after an accepted o_ren
// - m_axis_tvalid  out  1     output beat valid
// - m_axis_tdata   out  DLEN  output beat data
// - m_axis_tready  in   1     downstream ready
// - o_level        out  2     buffered entries currently held (0..DEPTH)
// BEHAVIOUR
// - Reset (rstn low, async): buffer count=0, in-flight pipe cleared, m_axis_tvalid=0, m_axis_tdata=0, o_level=0, o_ren forced 0.
//   Reads in flight at reset are discarded; the pointer block shares rstn, so no words are lost from FIFO accounting.
// - State: DEPTH-entry data buffer (head = entry 0), count[1:0], in-flight shift register infl[RD_LAT-1:0] (bit set = read issued).
// - pop = m_axis_tvalid & m_axis_tready; ret = infl[RD_LAT-1] (data arrives this cycle on i_ram_rdata).
// - Credit: o_ren = rstn & ~i_rempty & ((count + popcount(infl) - pop) < DEPTH). Purely combinational, same-cycle.
// - infl shifts every cycle; infl[0] <= o_ren.
// - Buffer update per cycle: pop removes head and shifts entries toward head; ret writes i_ram_rdata into slot (count - pop).
//   Simultaneous pop and ret: count unchanged, data order preserved. count_next = count + ret - pop; never exceeds DEPTH.
// - m_axis_tvalid = (count != 0); m_axis_tdata = buffer[0]; both registered (no combinational path from i_ram_rdata).
// - AXI-S rules: once tvalid=1 it holds with tdata stable until tready=1; beats emitted in exact FIFO read order.
// - Latency: i_rempty falls in cycle t with empty buffer -> o_ren in t -> m_axis_tvalid=1 in cycle t+RD_LAT+1.
// - Throughput: tready held 1 and FIFO non-empty -> one o_ren and one beat per cycle in steady state.
// - Backpressure: tready=0 -> buffer fills to DEPTH counting in-flight reads, then o_ren deasserts; resumes same cycle tready=1 pops.
// - Empty: i_rempty=1 -> o_ren=0 regardless of credit; buffered and in-flight words still drain normally.
// - ret asserted while count=DEPTH and no pop cannot occur (credit rule); assertion must flag it as an error.
// - o_level = count (excludes in-flight reads).
// TESTING
// - Reset mid-stream: assert rstn low async with count=2, infl!=0 -> tvalid=0, o_ren=0, o_level=0 immediately, no beat after release.
// - Single word, RD_LAT=1: i_rempty 1->0 at cycle 5, 0xA5A5_0001 returned cycle 6 -> tvalid=1 cycle 7 with tdata=0xA5A5_0001.
// - Streaming: 16 words 0..15, tready=1 throughout -> 16 consecutive beats 0..15, no bubbles after first; o_ren high 16 cycles.
// - Backpressure: tready=0 during streaming -> o_ren drops within 1 cycle, o_level reaches DEPTH, no data lost/duplicated on release.
// - Simultaneous pop+ret with count=1 -> count stays 1, next beat = returned word; random tready 50% over 1000 words, scoreboard order.
// - RD_LAT=2 build: repeat streaming and backpressure tests -> DEPTH=3, full-rate steady state, o_level never exceeds 3.

Source files
------------

// File: rtl/fifo_axis_rd_port.sv
// fifo_axis_rd_port
//   Read-side AXI-Stream master port of the FIFO. Requests words from the
//   read pointer block while the FIFO is non-empty and local buffer credit
//   exists, captures RAM read data RD_LAT cycles later into a small output
//   buffer, and presents it on m_axis_* with full backpressure support.
//   Sustains one beat per cycle while m_axis_tready is held high.
//
// Parameters
//   DLEN    data width (RAM word = tdata)
//   RD_LAT  RAM read latency from o_ren to valid i_ram_rdata (1 or 2)
//
// Ports
//   clk            clock
//   rstn           asynchronous active-low reset
//   i_rempty       FIFO empty flag from the read pointer block
//   o_ren          read request to the pointer block (never while i_rempty)
//   i_ram_rdata    RAM read data, valid RD_LAT cycles after an o_ren
//   m_axis_tvalid  output beat valid
//   m_axis_tdata   output beat data
//   m_axis_tready  downstream ready
//   o_level        words currently held in the output buffer (0..DEPTH)
module fifo_axis_rd_port #(
  parameter int unsigned DLEN   = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_rempty,
  output logic            o_ren,
  input  logic [DLEN-1:0] i_ram_rdata,
  output logic            m_axis_tvalid,
  output logic [DLEN-1:0] m_axis_tdata,
  input  logic            m_axis_tready,
  output logic [1:0]      o_level
);

  // One slot per possible in-flight read plus one being presented, which
  // is exactly what full-rate streaming needs.
  localparam int unsigned DEPTH = RD_LAT + 1;

  logic [DLEN-1:0]   buf_q [DEPTH];
  logic [DLEN-1:0]   buf_d [DEPTH];
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic [RD_LAT-1:0] infl_q;
  logic [RD_LAT-1:0] infl_d;
  logic              tvalid_q;

  logic              pop;
  logic              ret;
  logic [2:0]        outstanding;
  logic              credit;
  logic [1:0]        wr_slot;

  assign pop = tvalid_q & m_axis_tready;
  assign ret = infl_q[RD_LAT-1];

  // Credit counts buffered words plus reads still in the RAM pipe, so the
  // buffer can never be overrun by returning data. A pop in this cycle
  // frees a slot immediately, which keeps the stream gap-free.
  always_comb begin
    outstanding = {1'b0, count_q};
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      outstanding = outstanding + {2'b00, infl_q[i]};
    end
    credit = (outstanding - {2'b00, pop}) < 3'(DEPTH);
  end

  assign o_ren = rstn & ~i_rempty & credit;

  always_comb begin
    infl_d    = infl_q << 1;
    infl_d[0] = o_ren;
  end

  // Pop shifts toward the head first; the returning word then lands in the
  // first free slot after that shift, so pop+ret together keeps order.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      buf_d[i] = buf_q[i];
    end
    if (pop) begin
      for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
        buf_d[i] = buf_q[i+1];
      end
    end
    wr_slot = count_q - {1'b0, pop};
    if (ret) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (wr_slot == 2'(i)) begin
          buf_d[i] = i_ram_rdata;
        end
      end
    end
    count_d = count_q + {1'b0, ret} - {1'b0, pop};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
      count_q  <= '0;
      infl_q   <= '0;
      tvalid_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_q[i] <= buf_d[i];
      end
      count_q  <= count_d;
      infl_q   <= infl_d;
      tvalid_q <= (count_d != '0);
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = buf_q[0];
  assign o_level       = count_q;

  // A return into a full buffer with no pop would mean the credit logic
  // has been broken: that word would be dropped.
  always_ff @(posedge clk) begin
    if (rstn) begin
      assert (!(ret && !pop && (count_q == 2'(DEPTH))))
        else $error("fifo_axis_rd_port: read data returned into full buffer");
    end
  end

endmodule
